// File: rtl/cfs_md_rr_arbiter_if.sv
// MD request/aligner bundle for the round-robin arbiter: NUM_REQ requester lanes in, one aligner lane out.
// The slave modport is the arbiter side and the master modport is the requester/aligner side.
interface cfs_md_rr_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int ALGN_DATA_WIDTH = 32
);
  localparam int OW  = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8);
  localparam int SW  = $clog2(ALGN_DATA_WIDTH / 8) + 1;
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*OW-1:0]              req_offset;
  logic [NUM_REQ*SW-1:0]              req_size;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_err;
  logic                               md_valid;
  logic [ALGN_DATA_WIDTH-1:0]         md_data;
  logic [OW-1:0]                      md_offset;
  logic [SW-1:0]                      md_size;
  logic                               md_ready;
  logic                               md_err;
  logic                               grant_valid;
  logic [IDW-1:0]                     grant_id;

  modport slave (
    input  req_valid, req_data, req_offset, req_size, md_ready, md_err,
    output req_ready, req_err, md_valid, md_data, md_offset, md_size, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, req_offset, req_size, md_ready, md_err,
    input  req_ready, req_err, md_valid, md_data, md_offset, md_size, grant_valid, grant_id
  );
endinterface

// File: rtl/cfs_md_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ MD requesters onto one aligner input.
// A grant is released after BURST_LEN transfers or when the granted requester drops valid.
module cfs_md_rr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int BURST_LEN       = 2
) (
  input logic                  pclk,
  input logic                  preset_n,
  cfs_md_rr_arbiter_if.slave   bus
);
  localparam int OW  = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8);
  localparam int SW  = $clog2(ALGN_DATA_WIDTH / 8) + 1;
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0]   NUM_REQ_W  = NUM_REQ[IDW:0];
  localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);
  localparam logic [7:0]     BURST_LAST = 8'(BURST_LEN - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [7:0]     r_beat_cnt;
  logic           r_grant_valid;

  logic [IDW-1:0]             w_winner;
  logic [IDW:0]               w_sum;
  logic                       w_in_grant;
  logic                       w_g_valid;
  logic                       w_xfer;
  logic                       w_burst_end;
  logic                       w_release;
  logic [IDW-1:0]             w_next_ptr;
  logic [ALGN_DATA_WIDTH-1:0] w_slice_data   [NUM_REQ];
  logic [OW-1:0]              w_slice_offset [NUM_REQ];
  logic [SW-1:0]              w_slice_size   [NUM_REQ];

  // Descending scan so the lane closest to rr_ptr is assigned last and wins.
  always_comb begin
    w_winner = r_rr_ptr;
    w_sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      if (bus.req_valid[w_sum[IDW-1:0]]) begin
        w_winner = w_sum[IDW-1:0];
      end
    end
  end

  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_g_valid   = w_in_grant & bus.req_valid[r_grant_id];
  assign w_xfer      = w_g_valid & bus.md_ready;
  assign w_burst_end = (BURST_LEN != 0) && (r_beat_cnt == BURST_LAST);
  assign w_release   = w_in_grant && (!bus.req_valid[r_grant_id] || (w_xfer && w_burst_end));
  assign w_next_ptr  = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_slice_data[gi]   = bus.req_data[gi*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
      assign w_slice_offset[gi] = bus.req_offset[gi*OW +: OW];
      assign w_slice_size[gi]   = bus.req_size[gi*SW +: SW];
      assign bus.req_ready[gi]  = w_in_grant && (r_grant_id == IDW'(gi)) && bus.md_ready;
      assign bus.req_err[gi]    = w_xfer && (r_grant_id == IDW'(gi)) && bus.md_err;
    end
  endgenerate

  // The datapath is a pure mux: data, offset and size are never registered.
  assign bus.md_valid    = w_g_valid;
  assign bus.md_data     = w_in_grant ? w_slice_data[r_grant_id]   : '0;
  assign bus.md_offset   = w_in_grant ? w_slice_offset[r_grant_id] : '0;
  assign bus.md_size     = w_in_grant ? w_slice_size[r_grant_id]   : '0;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_beat_cnt    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            r_state       <= ST_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner;
            r_beat_cnt    <= '0;
          end
        end
        ST_GRANT: begin
          if (w_xfer && (r_beat_cnt != 8'hFF)) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          if (w_release) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cfs_md_rr_arbiter.sv
// Directed bench for cfs_md_rr_arbiter: one instance with BURST_LEN=2 and one with BURST_LEN=0.
// Lane i carries data D0D0000i, offset 3-i, size i+1.
module tb_cfs_md_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  cfs_md_rr_arbiter_if #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW)) bus  ();
  cfs_md_rr_arbiter_if #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW)) bus0 ();

  cfs_md_rr_arbiter #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW), .BURST_LEN(2)) u_dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  cfs_md_rr_arbiter #(.NUM_REQ(NR), .ALGN_DATA_WIDTH(DW), .BURST_LEN(0)) u_dut0 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus0)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    #3;
    @(negedge pclk);
    preset_n = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.md_ready   = 1'b0;
    bus.md_err     = 1'b0;
    bus0.req_valid = '0;
    bus0.md_ready  = 1'b0;
    bus0.md_err    = 1'b0;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int bad;

    clear_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i*DW +: DW]  = 32'hD0D0_0000 | i;
      bus.req_offset[i*2 +: 2]  = 2'(3 - i);
      bus.req_size[i*3 +: 3]    = 3'(i + 1);
      bus0.req_data[i*DW +: DW] = 32'hD0D0_0000 | i;
      bus0.req_offset[i*2 +: 2] = 2'(3 - i);
      bus0.req_size[i*3 +: 3]   = 3'(i + 1);
    end

    // Reset state
    #2;
    check("rst_grant_valid", bus.grant_valid, 0);
    check("rst_grant_id",    bus.grant_id,    0);
    check("rst_md_valid",    bus.md_valid,    0);
    check("rst_req_ready",   bus.req_ready,   0);
    check("rst_req_err",     bus.req_err,     0);
    check("rst_md_data",     bus.md_data,     0);
    do_reset();

    // Test 1: single requester 2
    bus.req_valid = 4'b0100;
    bus.md_ready  = 1'b1;
    #1;
    check("t1_c0_md_valid", bus.md_valid, 0);
    step();
    check("t1_c1_grant_valid", bus.grant_valid, 1);
    check("t1_c1_grant_id",    bus.grant_id,    2);
    check("t1_c1_md_valid",    bus.md_valid,    1);
    check("t1_c1_md_data",     bus.md_data,     32'hD0D0_0002);
    check("t1_c1_md_offset",   bus.md_offset,   1);
    check("t1_c1_md_size",     bus.md_size,     3);
    check("t1_c1_req_ready",   bus.req_ready,   4'b0100);
    step();
    check("t1_c2_grant_valid", bus.grant_valid, 1);
    step();
    check("t1_c3_grant_valid", bus.grant_valid, 0);
    check("t1_c3_md_valid",    bus.md_valid,    0);
    check("t1_c3_req_ready",   bus.req_ready,   0);
    check("t1_c3_md_data",     bus.md_data,     0);
    step();
    check("t1_c4_grant_valid", bus.grant_valid, 1);
    check("t1_c4_grant_id",    bus.grant_id,    2);
    clear_inputs();

    // Test 2: all four requesting, rotation 0,1,2,3,0
    do_reset();
    bus.req_valid = 4'b1111;
    bus.md_ready  = 1'b1;
    for (int r = 0; r < 5; r++) begin
      step();
      check("t2_grant_id_a",  bus.grant_id,    order[r]);
      check("t2_grant_vld_a", bus.grant_valid, 1);
      check("t2_md_data",     bus.md_data,     32'hD0D0_0000 | order[r]);
      step();
      check("t2_grant_id_b",  bus.grant_id,    order[r]);
      check("t2_grant_vld_b", bus.grant_valid, 1);
      step();
      check("t2_bubble",      bus.grant_valid, 0);
    end
    clear_inputs();

    // Test 3: backpressure on requester 1
    do_reset();
    bus.req_valid = 4'b0010;
    bus.md_ready  = 1'b0;
    step();
    check("t3_grant_id",  bus.grant_id,  1);
    check("t3_md_valid",  bus.md_valid,  1);
    check("t3_req_ready", bus.req_ready, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t3_hold_grant", bus.grant_valid, 1);
      check("t3_hold_valid", bus.md_valid,    1);
      check("t3_hold_ready", bus.req_ready,   0);
    end
    bus.md_ready = 1'b1;
    #1;
    check("t3_req_ready_on", bus.req_ready, 4'b0010);
    step();
    check("t3_second_beat", bus.grant_valid, 1);
    step();
    check("t3_released", bus.grant_valid, 0);
    step();
    check("t3_regrant_id",  bus.grant_id,    1);
    check("t3_regrant_vld", bus.grant_valid, 1);
    clear_inputs();

    // Test 4: error routing to requester 3
    do_reset();
    bus.req_valid = 4'b1000;
    bus.md_ready  = 1'b0;
    bus.md_err    = 1'b1;
    step();
    check("t4_grant_id",        bus.grant_id, 3);
    check("t4_err_no_transfer", bus.req_err,  0);
    bus.md_ready = 1'b1;
    #1;
    check("t4_err_routed",  bus.req_err,   4'b1000);
    check("t4_ready_route", bus.req_ready, 4'b1000);
    bus.md_err = 1'b0;
    step();
    check("t4_err_cleared", bus.req_err,     0);
    check("t4_still_grant", bus.grant_valid, 1);
    bus.md_err = 1'b1;
    step();
    check("t4_idle_grant", bus.grant_valid, 0);
    check("t4_idle_err",   bus.req_err,     0);
    clear_inputs();

    // Test 5: unlimited burst on the BURST_LEN=0 instance
    do_reset();
    bus0.req_valid = 4'b0011;
    bus0.md_ready  = 1'b1;
    step();
    check("t5_grant_id",  bus0.grant_id,    0);
    check("t5_grant_vld", bus0.grant_valid, 1);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (!(bus0.grant_valid === 1'b1 && bus0.grant_id === 2'd0 && bus0.md_valid === 1'b1)) begin
        bad++;
      end
    end
    check("t5_no_rotation", bad, 0);
    bus0.req_valid = 4'b0010;
    #1;
    check("t5_drop_md_valid", bus0.md_valid, 0);
    step();
    check("t5_idle", bus0.grant_valid, 0);
    step();
    check("t5_next_id",  bus0.grant_id,    1);
    check("t5_next_vld", bus0.grant_valid, 1);
    clear_inputs();

    // Test 6: asynchronous reset during a grant
    bus.req_valid = 4'b0100;
    step();
    check("t6_grant_id", bus.grant_id, 2);
    bus.md_ready = 1'b1;
    #2;
    preset_n = 1'b0;
    #1;
    check("t6_rst_grant_valid", bus.grant_valid, 0);
    check("t6_rst_grant_id",    bus.grant_id,    0);
    check("t6_rst_md_valid",    bus.md_valid,    0);
    check("t6_rst_req_ready",   bus.req_ready,   0);
    bus.req_valid = 4'b0101;
    @(negedge pclk);
    preset_n = 1'b1;
    step();
    check("t6_restart_id",  bus.grant_id,    0);
    check("t6_restart_vld", bus.grant_valid, 1);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
